spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  Serial front end for the single-port RAM. Deserialises MOSI frames into 10-bit words
//  (rx_data/rx_valid) that drive the RAM's din/rx_valid. On a read-data frame it takes the
//  RAM's dout/tx_valid and shifts the byte out on MISO, MSB first.
//  Exactly one frame per SS_n low window. SCK is the system clock: one bit per clk.
// PARAMETERS
//  RX_WIDTH  10  frame length in bits: [9:8] command, [7:0] address/data/dummy
//  TX_WIDTH  8   readout length in bits; equals RAM data width
// PORTS
//  clk       in   1         system clock, rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  SS_n      in   1         slave select, active low; frame framing
//  MOSI      in   1         serial data in, MSB first, sampled every clk while SS_n=0
//  rx_data   out  RX_WIDTH  completed frame; holding register; drives RAM din
//  rx_valid  out  1         one-cycle strobe; rx_data is new
//  tx_data   in   TX_WIDTH  RAM dout
//  tx_valid  in   1         RAM readout valid
//  MISO      out  1         serial data out, MSB first; 0 when not reading out
// BEHAVIOUR
//  Reset (async): state=IDLE; rx_data=0, rx_valid=0, MISO=0; bit counter=0; rd_addr_seen=0.
//  FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n=1 sampled in any state -> IDLE
//   next edge. Counter and shift register cleared. Partial frame discarded: no rx_valid.
//   rx_data is unchanged and MISO=0.
//  IDLE: SS_n=0 -> CHK_CMD.
//  CHK_CMD: the MOSI bit sampled here is frame bit 9 and is shifted in.
//   0 -> WRITE; 1 and rd_addr_seen=0 -> READ_ADD; 1 and rd_addr_seen=1 -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA: shift the remaining 9 bits, one per edge. The edge that samples
//   bit 0 copies the shifter to rx_data and sets rx_valid=1. rx_valid is 1 for exactly
//   the following cycle. Latency: SS_n fall seen at edge 0 -> rx_valid high after edge 10.
//  Bit 8 is not checked. The RAM decodes din[9:8].
//  READ_ADD: rd_addr_seen<=1 on the rx_valid edge. READ_DATA: rd_addr_seen<=0 on the rx_valid
//   edge. Aborted frames leave rd_addr_seen unchanged.
//  READ_DATA after rx_valid: wait for tx_valid=1, with no timeout. The first edge sampling
//   tx_valid=1 loads tx_data and drives MISO=tx_data[7]. The next 7 edges drive bits 6..0.
//   The following edge drives MISO=0. Further tx_valid cycles are ignored until SS_n rises.
//  After a frame completes with SS_n still 0: stay in the state, ignore MOSI, no new rx_valid.
//   Wait for SS_n=1.
//  SS_n rising mid-readout: MISO=0 next edge. The remaining bits are dropped.
//  Reset mid-frame: immediate return to reset values; no rx_valid is emitted.
// TESTING
//  1 Write addr: SS_n=0, MOSI=00_0101_0101 -> rx_data=0x055, one-cycle rx_valid
//    after edge 10; RAM write_addr=0x55.
//  2 Write data: MOSI=01_1010_0011 -> rx_data=0x1A3, rx_valid 1 cycle; mem[0x55]=0xA3.
//  3 Read addr then read data: 10_0101_0101 -> rx_data=0x255 and rd_addr_seen=1.
//    Then new SS_n window, 11_0000_0000 -> rx_data=0x300, FSM in READ_DATA. MISO=1,0,1,0,0,0,1,1
//    after tx_valid, then 0. rd_addr_seen=0.
//  4 Abort: SS_n rises after 5 bits of 01_1111_1111 -> no rx_valid, rx_data still 0x300,
//    mem[0x55] unchanged (0xA3), FSM IDLE.
//  5 Extra bits: 12 MOSI bits in one write window -> exactly one rx_valid; bits 11,12 ignored.
//  6 Reset mid-readout: assert rst_n=0 after 3 MISO bits -> MISO=0, rx_valid=0, IDLE at once.
//    The next 10_xxxx frame enters READ_ADD.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit command frames from
// MOSI into rx_data/rx_valid and serialises the RAM readout byte onto MISO, MSB first.
module spi_slave #(
    parameter int unsigned RX_WIDTH = 10,
    parameter int unsigned TX_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid,
    output logic                MISO
);

    localparam int unsigned CNT_W  = $clog2(RX_WIDTH + 1);
    localparam int unsigned TXC_W  = $clog2(TX_WIDTH + 2);
    localparam int unsigned SHFT_W = RX_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  bit_cnt;
    logic [SHFT_W-1:0] rx_shift;
    logic              rd_addr_seen;
    logic [TXC_W-1:0]  tx_cnt;
    logic [TX_WIDTH-1:0] tx_shift;

    logic shift_c;
    logic frame_end_c;
    logic tx_load_c;
    logic tx_shift_c;
    logic tx_last_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; SS_n high always returns to IDLE
    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI)             next_state = WRITE;
                    else if (rd_addr_seen) next_state = READ_DATA;
                    else                   next_state = READ_ADD;
                end
                default: next_state = state;
            endcase
        end
    end

    // Control strobes for the shift and readout datapath
    always_comb begin
        shift_c     = 1'b0;
        frame_end_c = 1'b0;
        tx_load_c   = 1'b0;
        tx_shift_c  = 1'b0;
        tx_last_c   = 1'b0;
        if (!SS_n) begin
            if ((state == WRITE || state == READ_ADD || state == READ_DATA) &&
                (bit_cnt < CNT_W'(RX_WIDTH))) begin
                shift_c     = 1'b1;
                frame_end_c = (bit_cnt == CNT_W'(RX_WIDTH - 1));
            end
            if (state == READ_DATA && bit_cnt == CNT_W'(RX_WIDTH)) begin
                tx_load_c  = (tx_cnt == '0) && tx_valid;
                tx_shift_c = (tx_cnt != '0) && (tx_cnt < TXC_W'(TX_WIDTH));
                tx_last_c  = (tx_cnt == TXC_W'(TX_WIDTH));
            end
        end
    end

    // Receive shifter, frame capture, read-address tracking and MISO serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_cnt       <= '0;
            tx_shift     <= '0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_cnt   <= '0;
                tx_shift <= '0;
                MISO     <= 1'b0;
            end else begin
                if (state == CHK_CMD) begin
                    rx_shift <= {rx_shift[SHFT_W-2:0], MOSI};
                    bit_cnt  <= CNT_W'(1);
                end
                if (shift_c) begin
                    rx_shift <= {rx_shift[SHFT_W-2:0], MOSI};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end
                if (frame_end_c) begin
                    rx_data  <= {rx_shift, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                    if (state == READ_DATA) rd_addr_seen <= 1'b0;
                end
                if (tx_load_c) begin
                    MISO     <= tx_data[TX_WIDTH-1];
                    tx_shift <= {tx_data[TX_WIDTH-2:0], 1'b0};
                    tx_cnt   <= TXC_W'(1);
                end
                if (tx_shift_c) begin
                    MISO     <= tx_shift[TX_WIDTH-1];
                    tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + TXC_W'(1);
                end
                if (tx_last_c) begin
                    MISO   <= 1'b0;
                    tx_cnt <= TXC_W'(TX_WIDTH + 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of frames with scoreboarded rx_data and MISO readout,
// plus hand sequences for SS_n abort mid-readout and reset mid-readout.
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;

    int checks = 0;
    int errors = 0;

    logic [9:0] rx_q[$];
    logic       miso_q[$];

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        bit         exp_valid;
        logic [9:0] exp_rx;
        bit         do_read;
        logic [7:0] rd_byte;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each rx_valid strobe must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data 0x%0h, expected none at %0t",
                         rx_data, $time);
            end else begin
                logic [9:0] e;
                e = rx_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data: got 0x%0h expected 0x%0h at %0t", rx_data, e, $time);
                end
            end
        end
    end

    // Drive one SS_n window: SS_n fall, then nbits MOSI bits; optionally keep SS_n low
    task automatic send_frame(input logic [9:0] f, input int nbits, input bit exp_valid,
                              input bit hold);
        if (exp_valid) rx_q.push_back(f);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            if (i == 10 && exp_valid) chk("rx_valid_latency", 32'(rx_valid), 32'd1);
            if (i == 11 && exp_valid) chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
            if (i < 10) MOSI = f[9-i];
            else        MOSI = 1'($urandom);
        end
        if (!hold) begin
            SS_n = 1'b1;
            @(negedge clk);
        end
    endtask

    // Present a RAM byte and check the 8 MISO bits then the trailing 0
    task automatic read_out(input logic [7:0] b);
        logic e;
        chk("miso_idle_wait", 32'(MISO), 32'd0);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 7; k >= 0; k--) miso_q.push_back(b[k]);
        miso_q.push_back(1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            e = miso_q.pop_front();
            chk("miso_bit", 32'(MISO), 32'(e));
        end
        tx_data  = ~b;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("miso_ignore_tx", 32'(MISO), 32'd0);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{10'h055,  10, 1'b1, 10'h055, 1'b0, 8'h00};
        vecs[1] = '{10'h1A3,  10, 1'b1, 10'h1A3, 1'b0, 8'h00};
        vecs[2] = '{10'h255,  10, 1'b1, 10'h255, 1'b0, 8'h00};
        vecs[3] = '{10'h300,  10, 1'b1, 10'h300, 1'b1, 8'hA3};
        vecs[4] = '{10'h1FF,   5, 1'b0, 10'h300, 1'b0, 8'h00};
        vecs[5] = '{10'h0C7,  12, 1'b1, 10'h0C7, 1'b0, 8'h00};
        vecs[6] = '{10'h2AA,  10, 1'b1, 10'h2AA, 1'b0, 8'h00};
        vecs[7] = '{10'h3FF,  10, 1'b1, 10'h3FF, 1'b1, 8'h5C};

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_miso", 32'(MISO), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].frame, vecs[v].nbits, vecs[v].exp_valid, vecs[v].do_read);
            if (vecs[v].do_read) begin
                @(negedge clk);
                read_out(vecs[v].rd_byte);
                SS_n = 1'b1;
                @(negedge clk);
            end
            chk("rx_data_hold", 32'(rx_data), 32'(vecs[v].exp_rx));
            chk("miso_after_frame", 32'(MISO), 32'd0);
        end

        // SS_n rises mid-readout: remaining bits dropped
        send_frame(10'h211, 10, 1'b1, 1'b0);
        send_frame(10'h3EE, 10, 1'b1, 1'b1);
        @(negedge clk);
        tx_data  = 8'hB5;
        tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; chk("abort_miso_b7", 32'(MISO), 32'd1);
        @(negedge clk); chk("abort_miso_b6", 32'(MISO), 32'd0);
        @(negedge clk); chk("abort_miso_b5", 32'(MISO), 32'd1);
        SS_n = 1'b1;
        @(negedge clk); chk("abort_miso_zero", 32'(MISO), 32'd0);
        repeat (3) begin
            @(negedge clk); chk("abort_miso_stays", 32'(MISO), 32'd0);
        end

        // Reset mid-readout: immediate return to reset values
        send_frame(10'h244, 10, 1'b1, 1'b0);
        send_frame(10'h3C0, 10, 1'b1, 1'b1);
        @(negedge clk);
        tx_data  = 8'hE1;
        tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; chk("rst_miso_b7", 32'(MISO), 32'd1);
        @(negedge clk); chk("rst_miso_b6", 32'(MISO), 32'd1);
        @(negedge clk); chk("rst_miso_b5", 32'(MISO), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_miso", 32'(MISO), 32'd0);
        chk("rst_async_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_async_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset a 1x frame is a read address: no readout on tx_valid
        send_frame(10'h277, 10, 1'b1, 1'b1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (6) begin
            @(negedge clk); chk("read_add_no_miso", 32'(MISO), 32'd0);
        end
        tx_valid = 1'b0;
        SS_n = 1'b1;
        @(negedge clk);
        send_frame(10'h300, 10, 1'b1, 1'b1);
        @(negedge clk);
        read_out(8'h3C);
        SS_n = 1'b1;
        @(negedge clk);

        repeat (3) @(negedge clk);
        chk("rx_queue_empty", 32'(rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
